// File: rtl/wb_pkg.sv
// wb_pkg: opcode and condition encodings, sequencer states and the
// per-opcode writeback decision shared by the writeback controller.
package wb_pkg;
   localparam logic [3:0] OP_ADI  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_NAND = 4'b0010;
   localparam logic [3:0] OP_LHI  = 4'b0011;
   localparam logic [3:0] OP_LW   = 4'b0100;
   localparam logic [3:0] OP_SW   = 4'b0101;
   localparam logic [3:0] OP_LM   = 4'b0110;
   localparam logic [3:0] OP_SM   = 4'b0111;
   localparam logic [3:0] OP_JAL  = 4'b1100;
   localparam logic [3:0] OP_JLR  = 4'b1101;
   localparam logic [1:0] CZ_ALW  = 2'b00;
   localparam logic [1:0] CZ_Z    = 2'b01;
   localparam logic [1:0] CZ_C    = 2'b10;
   localparam logic [1:0] CZ_RSV  = 2'b11;
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_SEQ  = 1'b1;
   // reserved cz counts as "always" for ADD but as "never" for NAND
   function automatic logic wr_decision(input logic [3:0] op, input logic [1:0] cz,
                                        input logic c, input logic z);
      case (op)
         OP_ADI, OP_LHI, OP_LW, OP_JAL, OP_JLR: return 1'b1;
         OP_ADD:  return cz == CZ_C ? c : cz == CZ_Z ? z : 1'b1;
         OP_NAND: return cz == CZ_ALW ? 1'b1 : cz == CZ_C ? c : cz == CZ_Z ? z : 1'b0;
         default: return 1'b0;
      endcase
   endfunction
endpackage

// File: rtl/lowest_set_idx.sv
// lowest_set_idx: priority encoder returning the index of the lowest set bit.
module lowest_set_idx #(
   parameter int N  = 8,
   parameter int AW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   output logic [AW-1:0] idx,
   output logic          found
);
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = AW'(i);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/wb_write_ctrl.sv
// wb_write_ctrl: register-file write enable with conditional writes, stall/flush
// suppression and one-register-per-cycle sequencing of Load-Multiple.
module wb_write_ctrl
   import wb_pkg::*;
#(
   parameter int NREG = 8,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_in,
   input  logic            stall,
   input  logic            invalid,
   input  logic [3:0]      op,
   input  logic [1:0]      cz,
   input  logic            c_flag,
   input  logic            z_flag,
   input  logic [AW-1:0]   rd,
   input  logic [NREG-1:0] reg_list,
   output logic            reg_write,
   output logic [AW-1:0]   wr_addr,
   output logic            busy
);
   state_t          state;
   logic [NREG-1:0] mask;
   logic [NREG-1:0] mask_rest;
   logic [AW-1:0]   next_idx;
   logic            found;
   logic            accept;

   lowest_set_idx #(.N(NREG), .AW(AW)) u_pick (
      .vec   (mask),
      .idx   (next_idx),
      .found (found)
   );

   assign busy      = state == ST_SEQ;
   assign accept    = valid_in & ~busy & ~stall & ~invalid;
   assign mask_rest = mask & ~(NREG'(1) << next_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         mask      <= '0;
         reg_write <= 1'b0;
         wr_addr   <= '0;
      end else begin
         reg_write <= 1'b0;
         if (invalid) begin
            state <= ST_IDLE;
            mask  <= '0;
         end else if (busy) begin
            if (!stall && found) begin
               reg_write <= 1'b1;
               wr_addr   <= next_idx;
               mask      <= mask_rest;
               if (mask_rest == '0) state <= ST_IDLE;
            end
         end else if (accept) begin
            if (op == OP_LM) begin
               if (|reg_list) begin
                  mask  <= reg_list;
                  state <= ST_SEQ;
               end
            end else begin
               reg_write <= wr_decision(op, cz, c_flag, z_flag);
               wr_addr   <= rd;
            end
         end
      end
   end
endmodule
